// File: rtl/regfile_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
//
// Purpose:
//   Shared constants and types for the register-file write-port arbiter and
//   for the writeback sources that feed it.
//   - Register-file geometry: REG_ADDR_W, REG_DATA_W, REG_COUNT.
//   - Requester slot numbers: REQ_ALU, REQ_LOAD, REQ_DBG.
//   - wr_entry_t: one pending write (destination and data).
//   - is_zero_reg(): true for x0, whose writes are consumed but never
//     reach the register file.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

  // Register-file geometry shared by every block on the write path.
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  // Fixed slot numbers of the writeback sources on the arbiter's request
  // vectors. A lower slot number does not mean higher priority, because
  // the arbiter rotates.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // One buffered write, as held in a requester's holding slot.
  typedef struct packed {
    reg_addr_t rd;
    reg_data_t wdata;
  } wr_entry_t;

  // x0 is hard-wired to zero in the register file. A write that targets it
  // still has to be drained from its buffer, but it must not assert the
  // write enable.
  function automatic logic is_zero_reg(input reg_addr_t rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purpose:
//   Purely combinational round-robin arbiter. Starting at slot 'ptr' and
//   wrapping around, it grants the first slot whose request is set. The
//   grant is one-hot, or all zero when nothing requests. The caller owns
//   the pointer, so it decides when and how the rotation advances. This
//   lets other shared-resource blocks reuse the arbiter unchanged.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//
// Ports:
//   req    input  [NREQ-1:0]   request per slot
//   ptr    input  [PTR_W-1:0]  slot that has highest priority this cycle
//   grant  output [NREQ-1:0]   one-hot grant (zero if no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  // Walk the slots in priority order ptr, ptr+1, ... wrapping at NREQ. The
  // first slot that requests wins. The 'found' flag ensures that at most
  // one grant bit is set, even though every slot is visited.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Shares the single write port of the 32x32 register file among NREQ
//   writeback sources. Each source has a one-entry holding buffer with a
//   valid/ready handshake. A round-robin arbiter drains at most one
//   buffered write per cycle into registered RD/WData/RegWr, which drive
//   the register file's write port directly. A granted buffer can be
//   refilled on the same edge, so a lone requester sustains one write per
//   cycle. Writes to x0 are drained but leave RegWr low.
//
// Configuration:
//   REGARB_PENDING_EN  when defined, 'pending' is a register that tracks
//                      the destinations with an accepted but not yet
//                      committed write. When undefined, 'pending' is tied
//                      to zero and no tracking logic exists.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//
// Ports:
//   Clk         input            clock, rising edge
//   Reset       input            asynchronous active-high reset
//   req_valid   input  [NREQ]    requester i presents a write
//   req_rd      input  [5*NREQ]  destination of requester i, [5i+4:5i]
//   req_wdata   input  [32*NREQ] data of requester i, [32i+31:32i]
//   req_ready   output [NREQ]    buffer i accepts this cycle
//   RD          output [5]       register-file write address (registered)
//   WData       output [32]      register-file write data (registered)
//   RegWr       output           register-file write enable (registered)
//   busy        output           any buffer full or RegWr high
//   pending     output [32]      registers with an outstanding write
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NREQ-1:0] req_rd,
  input  logic [REG_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]      RD,
  output logic [REG_DATA_W-1:0]      WData,
  output logic                       RegWr,
  output logic                       busy,
  output logic [REG_COUNT-1:0]       pending
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_entry_t        r_buf [NREQ];
  logic [NREQ-1:0]  r_buf_full;
  logic [PTR_W-1:0] r_ptr;
  reg_addr_t        r_rd;
  reg_data_t        r_wdata;
  logic             r_regwr;

  wr_entry_t        w_req_entry [NREQ];
  logic [NREQ-1:0]  w_grant;
  logic [NREQ-1:0]  w_accept;
  logic             w_grant_any;
  logic [PTR_W-1:0] w_grant_idx;
  wr_entry_t        w_grant_entry;

  // Unpack the flat request buses into one entry per requester, so the
  // rest of the block can work with slot indices instead of bit slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_req_entry[i].rd    = req_rd[REG_ADDR_W*i +: REG_ADDR_W];
      w_req_entry[i].wdata = req_wdata[REG_DATA_W*i +: REG_DATA_W];
    end
  end

  // The arbiter looks only at which buffers are full. Incoming requests
  // never compete directly: a write must first be buffered for one edge.
  // This keeps req_valid out of the grant path, and therefore out of the
  // req_ready path.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req   (r_buf_full),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_grant_any = |w_grant;

  // A granted buffer is being emptied on this edge, so it may take a new
  // write at the same time. This refill-on-grant path gives a lone
  // requester a throughput of one write per cycle.
  assign req_ready = ~r_buf_full | w_grant;
  assign w_accept  = req_valid & req_ready;

  // Convert the one-hot grant to a slot index and select the granted
  // entry. If nothing is granted, both default to zero. In that case the
  // selected entry is not used, because the output registers hold.
  always_comb begin
    w_grant_idx   = '0;
    w_grant_entry = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_grant_idx   = PTR_W'(i);
        w_grant_entry = r_buf[i];
      end
    end
  end

  // Holding buffers. An accept takes priority over the grant-clear, so a
  // refill on the grant edge leaves the buffer full with the new write.
  // Reset discards every buffered write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_buf_full <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept[i]) begin
          r_buf[i]      <= w_req_entry[i];
          r_buf_full[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_buf_full[i] <= 1'b0;
        end
      end
    end
  end

  // The rotation pointer moves to the slot after the winner, so that slot
  // is searched first on the next cycle. This bounds any full buffer's
  // wait to NREQ-1 grants. Without a grant the pointer stays put, so an
  // idle cycle does not skip anyone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      if (int'(w_grant_idx) == NREQ - 1) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant_idx + 1'b1;
      end
    end
  end

  // Register-file write port. RD/WData update only on a grant and hold
  // otherwise, so the port does not toggle while idle. RegWr is a
  // one-cycle pulse per committed write. For x0 it stays low: the write
  // has left its buffer, but it never reaches the register file.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd    <= '0;
      r_wdata <= '0;
      r_regwr <= 1'b0;
    end else if (w_grant_any) begin
      r_rd    <= w_grant_entry.rd;
      r_wdata <= w_grant_entry.wdata;
      r_regwr <= !is_zero_reg(w_grant_entry.rd);
    end else begin
      r_regwr <= 1'b0;
    end
  end

  assign RD    = r_rd;
  assign WData = r_wdata;
  assign RegWr = r_regwr;
  assign busy  = (|r_buf_full) | r_regwr;

`ifdef REGARB_PENDING_EN

  logic [REG_COUNT-1:0] r_pending;
  logic [REG_COUNT-1:0] w_pending_next;
  logic                 w_pending_keep;

  // Next value of the outstanding-write map.
  // Commit side: the bit for the granted destination is cleared on the
  // edge that drives RegWr for it. If another buffer that stays full
  // still targets the same register, the bit is kept.
  // Accept side: every accept with rd != 0 sets its bit. The sets are
  // applied after the clear, so a same-edge accept to the committing
  // register keeps the bit set.
  // Bit 0 is forced low because x0 can never hold a pending value.
  always_comb begin
    w_pending_next = r_pending;
    w_pending_keep = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_buf_full[i] && !w_grant[i] && (r_buf[i].rd == w_grant_entry.rd)) begin
        w_pending_keep = 1'b1;
      end
    end
    if (w_grant_any && !is_zero_reg(w_grant_entry.rd) && !w_pending_keep) begin
      w_pending_next[w_grant_entry.rd] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept[i] && !is_zero_reg(w_req_entry[i].rd)) begin
        w_pending_next[w_req_entry[i].rd] = 1'b1;
      end
    end
    w_pending_next[0] = 1'b0;
  end

  // Reset clears the map, together with the buffered writes it describes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;

`else

  assign pending = '0;

`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Directed bench for regfile_wr_arbiter with NREQ=3. The stimulus thread
// pushes each write it expects to be committed, in commit order, into a
// scoreboard queue. A separate monitor pops the queue on every RegWr pulse
// and compares RD/WData. The stimulus thread also makes direct checks of
// handshake, latency, reset and pending behaviour. If REGARB_PENDING_EN
// is defined, the pending expectations follow it.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int NREQ = 3;

`ifdef REGARB_PENDING_EN
  localparam logic PEND_EN = 1'b1;
`else
  localparam logic PEND_EN = 1'b0;
`endif

  typedef struct {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] wdata;
  } exp_t;

  logic                       Clk = 1'b0;
  logic                       Reset;
  logic [NREQ-1:0]            req_valid;
  logic [REG_ADDR_W*NREQ-1:0] req_rd;
  logic [REG_DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]            req_ready;
  logic [REG_ADDR_W-1:0]      RD;
  logic [REG_DATA_W-1:0]      WData;
  logic                       RegWr;
  logic                       busy;
  logic [REG_COUNT-1:0]       pending;

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;
  bit   monitorOn  = 1'b0;

  // Hand-computed streaming schedule: requester 1 streams to rd=10, and
  // requester 2 holds a single write to rd=20.
  logic        t3Valid1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        t3Valid2 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] t3Data1  [6] = '{32'h100, 32'h101, 32'h102, 32'h102, 32'h103, 32'h0};
  logic        t3Ready1 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  regfile_wr_arbiter #(
    .NREQ (NREQ)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .RD        (RD),
    .WData     (WData),
    .RegWr     (RegWr),
    .busy      (busy),
    .pending   (pending)
  );

  // Free-running clock with a period of 10 time units.
  always #5 Clk = ~Clk;

  // Single comparison point. Every check is counted here, and every
  // mismatch is reported on one line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive all three requester slots at once.
  task automatic applyStimulus(input logic [NREQ-1:0] valid,
                               input logic [4:0] rd0, input logic [4:0] rd1,
                               input logic [4:0] rd2,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2);
    req_valid = valid;
    req_rd[REG_ADDR_W*REQ_ALU  +: REG_ADDR_W] = rd0;
    req_rd[REG_ADDR_W*REQ_LOAD +: REG_ADDR_W] = rd1;
    req_rd[REG_ADDR_W*REQ_DBG  +: REG_ADDR_W] = rd2;
    req_wdata[REG_DATA_W*REQ_ALU  +: REG_DATA_W] = d0;
    req_wdata[REG_DATA_W*REQ_LOAD +: REG_DATA_W] = d1;
    req_wdata[REG_DATA_W*REQ_DBG  +: REG_DATA_W] = d2;
  endtask

  task automatic pushExpected(input logic [4:0] rd, input logic [31:0] wdata);
    exp_t e;
    e.rd    = rd;
    e.wdata = wdata;
    sbQueue.push_back(e);
  endtask

  task automatic idleInputs();
    applyStimulus('0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every RegWr pulse must match the oldest expected commit.
  // A pulse that arrives with nothing expected is a failure.
  always @(negedge Clk) begin
    if (monitorOn && !Reset && RegWr) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_unexpected_regwr", 32'(RegWr), 32'd0);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_rd", 32'(RD), 32'(e.rd));
        checkOutput("sb_wdata", WData, e.wdata);
      end
    end
  end

  // Watchdog, so that the bench cannot run forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    idleInputs();
    #12;
    checkOutput("rst_regwr", 32'(RegWr), 32'd0);
    checkOutput("rst_rd", 32'(RD), 32'd0);
    checkOutput("rst_wdata", WData, 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'h7);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pending", pending, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    monitorOn = 1'b1;

    $display("[TB] single write, rd=5");
    @(posedge Clk); #1;
    applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    pushExpected(5'd5, 32'hDEADBEEF);
    @(negedge Clk);
    checkOutput("t1_ready_before", 32'(req_ready), 32'h7);
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    checkOutput("t1_regwr_e0", 32'(RegWr), 32'd0);
    checkOutput("t1_busy_e0", 32'(busy), 32'd1);
    checkOutput("t1_pend5_e0", 32'(pending[5]), 32'(PEND_EN));
    @(negedge Clk);
    checkOutput("t1_regwr_e1", 32'(RegWr), 32'd1);
    checkOutput("t1_rd_e1", 32'(RD), 32'd5);
    checkOutput("t1_wdata_e1", WData, 32'hDEADBEEF);
    checkOutput("t1_pend5_e1", 32'(pending[5]), 32'd0);
    @(negedge Clk);
    checkOutput("t1_regwr_e2", 32'(RegWr), 32'd0);
    checkOutput("t1_busy_e2", 32'(busy), 32'd0);

    Reset = 1'b1;
    sbQueue.delete();
    @(negedge Clk);
    Reset = 1'b0;

    $display("[TB] three simultaneous accepts at ptr=0");
    @(posedge Clk); #1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    pushExpected(5'd1, 32'h11);
    pushExpected(5'd2, 32'h22);
    pushExpected(5'd3, 32'h33);
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    checkOutput("t2_ready_all_full", 32'(req_ready), 32'h1);
    @(negedge Clk);
    checkOutput("t2_rd_c1", 32'(RD), 32'd1);
    checkOutput("t2_ready_c1", 32'(req_ready), 32'h3);
    @(negedge Clk);
    checkOutput("t2_rd_c2", 32'(RD), 32'd2);
    @(negedge Clk);
    checkOutput("t2_rd_c3", 32'(RD), 32'd3);
    @(negedge Clk);
    checkOutput("t2_regwr_idle", 32'(RegWr), 32'd0);

    $display("[TB] pointer back at 0: slot 0 must beat slot 2");
    @(posedge Clk); #1;
    applyStimulus(3'b101, 5'd8, 5'd0, 5'd9, 32'h88, 32'd0, 32'h99);
    pushExpected(5'd8, 32'h88);
    pushExpected(5'd9, 32'h99);
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("t2b_first_rd", 32'(RD), 32'd8);
    @(negedge Clk);
    checkOutput("t2b_second_rd", 32'(RD), 32'd9);
    @(negedge Clk);

    $display("[TB] requester 1 streams, requester 2 holds one write");
    pushExpected(5'd10, 32'h100);
    pushExpected(5'd20, 32'h200);
    pushExpected(5'd10, 32'h101);
    pushExpected(5'd10, 32'h102);
    pushExpected(5'd10, 32'h103);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      applyStimulus({t3Valid2[k], t3Valid1[k], 1'b0}, 5'd0, 5'd10, 5'd20,
                    32'd0, t3Data1[k], 32'h200);
      @(negedge Clk);
      checkOutput($sformatf("t3_ready1_c%0d", k), 32'(req_ready[1]), 32'(t3Ready1[k]));
      if (k == 3) begin
        checkOutput("t3_req2_commit_rd", 32'(RD), 32'd20);
        checkOutput("t3_req2_commit_regwr", 32'(RegWr), 32'd1);
      end
    end
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("t3_regwr_done", 32'(RegWr), 32'd0);

    $display("[TB] writes to x0 are dropped");
    @(posedge Clk); #1;
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF);
    @(negedge Clk);
    checkOutput("t4_ready_c0", 32'(req_ready[2]), 32'd1);
    @(posedge Clk); #1;
    @(negedge Clk);
    checkOutput("t4_ready_c1", 32'(req_ready[2]), 32'd1);
    checkOutput("t4_regwr_c1", 32'(RegWr), 32'd0);
    checkOutput("t4_busy_c1", 32'(busy), 32'd1);
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    checkOutput("t4_regwr_c2", 32'(RegWr), 32'd0);
    checkOutput("t4_pend0", 32'(pending[0]), 32'd0);
    @(negedge Clk);
    checkOutput("t4_regwr_c3", 32'(RegWr), 32'd0);
    checkOutput("t4_busy_c3", 32'(busy), 32'd0);

    $display("[TB] reset with every buffer full");
    @(posedge Clk); #1;
    applyStimulus(3'b111, 5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'h66);
    pushExpected(5'd4, 32'h44);
    @(posedge Clk); #1;
    applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 32'd0, 32'd0);
    @(negedge Clk);
    checkOutput("t5_ready_full", 32'(req_ready), 32'h1);
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    checkOutput("t5_regwr_before_reset", 32'(RegWr), 32'd1);
    checkOutput("t5_busy_before_reset", 32'(busy), 32'd1);
    #1;
    Reset = 1'b1;
    sbQueue.delete();
    #1;
    checkOutput("t5_regwr_async", 32'(RegWr), 32'd0);
    checkOutput("t5_busy_async", 32'(busy), 32'd0);
    @(posedge Clk);
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("t5_busy_after", 32'(busy), 32'd0);
    checkOutput("t5_ready_after", 32'(req_ready), 32'h7);
    checkOutput("t5_pending_after", pending, 32'd0);
    checkOutput("t5_regwr_after_c0", 32'(RegWr), 32'd0);
    @(negedge Clk);
    checkOutput("t5_regwr_after_c1", 32'(RegWr), 32'd0);

    $display("[TB] two writes to rd=7 from requesters 0 and 1");
    @(posedge Clk); #1;
    applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 32'hA, 32'd0, 32'd0);
    pushExpected(5'd7, 32'hA);
    pushExpected(5'd7, 32'hB);
    @(negedge Clk);
    checkOutput("t6_pend7_c0", 32'(pending[7]), 32'd0);
    @(posedge Clk); #1;
    applyStimulus(3'b010, 5'd0, 5'd7, 5'd0, 32'd0, 32'hB, 32'd0);
    @(negedge Clk);
    checkOutput("t6_pend7_first_accept", 32'(pending[7]), 32'(PEND_EN));
    @(posedge Clk); #1;
    idleInputs();
    @(negedge Clk);
    checkOutput("t6_pend7_first_commit", 32'(pending[7]), 32'(PEND_EN));
    checkOutput("t6_wdata_first", WData, 32'hA);
    @(negedge Clk);
    checkOutput("t6_pend7_second_commit", 32'(pending[7]), 32'd0);
    checkOutput("t6_wdata_second", WData, 32'hB);
    checkOutput("t6_regwr_second", 32'(RegWr), 32'd1);
    @(negedge Clk);
    checkOutput("t6_regwr_idle", 32'(RegWr), 32'd0);
    checkOutput("t6_pend0", 32'(pending[0]), 32'd0);

    @(negedge Clk);
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32×32 register file (RD/WData/RegWr) among NREQ independent writeback sources, such as ALU result, load data and debug/host write. Each source has a valid/ready handshake into a one-entry holding buffer. A round-robin arbiter drains at most one buffered write per cycle into registered RD/WData/RegWr outputs. The block sits between the writeback sources and the register file, and its outputs drive the file's write port directly.

## Interface
- NREQ, 3, number of requesters (2..8)
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- req_valid  input  NREQ  requester i presents a write
- req_rd  input  5*NREQ  destination register of requester i, bits [5i+4:5i]
- req_wdata  input  32*NREQ  write data of requester i, bits [32i+31:32i]
- req_ready  output  NREQ  requester i's buffer accepts this cycle
- RD  output  5  register-file write address (registered)
- WData  output  32  register-file write data (registered)
- RegWr  output  1  register-file write enable (registered, one-cycle pulse per write)
- busy  output  1  any buffer full or RegWr high
- pending  output  32  registers with an accepted, not-yet-written value (REGARB_PENDING_EN only; otherwise tied 0)

## Operation
- Per requester: buf_full, buf_rd[4:0], buf_wdata[31:0].
- Accept: on a rising edge where req_valid[i] & req_ready[i], load the buffer and set buf_full.
- req_ready[i] = ~buf_full[i] | grant[i]. A full buffer that is granted accepts a refill in the same cycle.
- Arbitration is combinational over buf_full. It uses a round-robin search starting at pointer ptr (0..NREQ-1), and the first full buffer at or after ptr wrapping is granted. At most one grant per cycle.
- On a grant to i:
  - Next edge: RD<=buf_rd[i], WData<=buf_wdata[i], buf_full[i] cleared unless refilled, ptr<=(i+1) mod NREQ.
  - RegWr<=1 if buf_rd[i]!=0, else RegWr<=0. A write to x0 is consumed and dropped.
- With no grant: RegWr<=0, ptr unchanged, RD/WData hold their previous values.
- Same-destination writes from different requesters are committed in grant order. Program-order correctness across requesters is the requesters' responsibility.

## Timing
- Reset values: RegWr=0, RD=0, WData=0, buf_full=0, ptr=0, req_ready=all 1, busy=0, pending=0.
- Latency, single write with no contention:
  - Edge E0 accepts the write.
  - Edge E1 drives RegWr=1 with RD/WData.
  - The register file captures the write at E2.
  - The written value is readable from the register file after E2.
- Throughput: one committed write per cycle in aggregate, and one per cycle per requester when it is alone (refill-on-grant).
- Worst-case wait for a full buffer: NREQ-1 grants.
- Simultaneous accepts by all NREQ requesters at one edge are legal.
- Reset asserted mid-operation: all buffered writes are discarded and RegWr deasserts immediately (asynchronously). A write already presented on RegWr at the time is lost.
- req_valid may drop without acceptance; there is no stability requirement before acceptance.

## Configuration
- REGARB_PENDING_EN defined: `pending` is maintained as a 32-bit register.
  - Set bit rd on accept when rd!=0.
  - Clear bit rd on the edge RegWr is driven for it, unless another buffered or same-edge-accepted write targets the same rd.
  - Bit 0 is always 0.
  - Used by the hazard/stall logic.
- Not defined: `pending` is constant 0 and no tracking logic is synthesised.

## Structure
- Shared package holds REG_ADDR_W=5, REG_DATA_W=32 and REG_COUNT=32. Requesters use these constants for their index definitions (REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2).
- Sub-module rr_arbiter: parameterised NREQ, with inputs req and ptr and a one-hot grant output. It is reused by other shared-resource blocks.

## Test plan
- Single write: requester 0 writes rd=5, wdata=0xDEADBEEF. The block drives RegWr=1, RD=5, WData=0xDEADBEEF exactly one cycle after acceptance, and RegWr returns to 0 the next cycle.
- Three simultaneous accepts at ptr=0 (rd=1/2/3, data 0x11/0x22/0x33) commit on three consecutive cycles in order 1,2,3, and ptr ends at 0.
- Requester 1 streams continuously while requester 2 holds one write. The write for requester 2 commits within 2 cycles, and requester 1's req_ready never stays low for more than 1 cycle.
- Write to x0 with data 0xFFFFFFFF: the write is accepted and req_ready stays 1. RegWr stays 0 for the whole sequence, and pending bit 0 stays 0.
- Reset asserted with all buffers full: RegWr falls without a clock edge. After release, busy=0, req_ready=all 1, and no write issues.
- With REGARB_PENDING_EN: requesters 0 and 1 both write rd=7 back-to-back. pending[7] is set on the first accept and clears only after the second write's RegWr edge.
